// File: rtl/bg_pkg.sv
// Shared definitions for the background memory writer.
//   SCREEN_W/SCREEN_H/BG_PIXELS : background resolution (half of the VGA scan)
//   bg_wr_state_t               : writer FSM states
//   bg_token_t                  : one run-length token {run-1, palette index}
package bg_pkg;

    localparam int unsigned SCREEN_W    = 320;
    localparam int unsigned SCREEN_H    = 240;
    localparam int unsigned BG_PIXELS   = SCREEN_W * SCREEN_H;
    localparam int unsigned TOKEN_RUN_W = 5;

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StRun,
        StDone
    } bg_wr_state_t;

    typedef struct packed {
        logic [TOKEN_RUN_W-1:0] run;     // run length minus one
        logic [2:0]             colour;  // palette index
    } bg_token_t;

endpackage

// File: rtl/raster_counter.sv
// Raster position tracker for the background writer.
//   Clk, Reset  : clock, asynchronous active-high reset
//   clear       : return to pixel (0,0), address 0
//   advance     : step to the next pixel in raster order
//   addr        : linear address y*WIDTH + x, kept as its own counter
//   last_pixel  : current position is the final pixel of the frame
module raster_counter
    import bg_pkg::*;
#(
    parameter int unsigned WIDTH  = SCREEN_W,
    parameter int unsigned HEIGHT = SCREEN_H,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last_pixel
);

    logic [8:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clear) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (advance) begin
            if (x_q == 9'(WIDTH - 1)) begin
                x_d = '0;
                y_d = y_q + 8'd1;
            end else begin
                x_d = x_q + 9'd1;
            end
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign addr       = addr_q;
    assign last_pixel = (x_q == 9'(WIDTH - 1)) && (y_q == 8'(HEIGHT - 1));

endmodule

// File: rtl/background_writer.sv
// Fills the background RAM from a run-length-encoded token stream, one pixel
// write per cycle in raster order.
//   Clk, Reset  : clock, asynchronous active-high reset
//   start       : pulse, begins a frame load (only seen in IDLE)
//   in_valid    : token valid
//   in_data     : token, [RUN_W+2:3] = run-1, [2:0] = palette index
//   in_ready    : token accepted when in_valid && in_ready
//   wr_en       : RAM write strobe
//   wr_addr     : RAM write address, y*WIDTH + x
//   wr_data     : palette index written
//   busy        : loading a frame (ACCEPT or RUN)
//   done        : one-cycle pulse after the last pixel is written
//   overrun     : sticky, a run extended past the final pixel
module background_writer
    import bg_pkg::*;
#(
    parameter int unsigned WIDTH  = SCREEN_W,
    parameter int unsigned HEIGHT = SCREEN_H,
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned RUN_W  = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [RUN_W+2:0]  in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    bg_wr_state_t      state_q, state_d;
    logic [RUN_W-1:0]  rem_q, rem_d;
    logic [2:0]        colour_q, colour_d;
    logic              overrun_q, overrun_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rc_clear, rc_advance, last_pixel;
    logic [ADDR_W-1:0] rc_addr;

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_raster (
        .Clk        (Clk),
        .Reset      (Reset),
        .clear      (rc_clear),
        .advance    (rc_advance),
        .addr       (rc_addr),
        .last_pixel (last_pixel)
    );

    // State and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            colour_q   <= '0;
            overrun_q  <= 1'b0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            colour_q   <= colour_d;
            overrun_q  <= overrun_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next state
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        colour_d  = colour_q;
        overrun_d = overrun_q;
        unique case (state_q)
            StIdle: begin
                // overrun stays visible after a frame until the next load begins
                if (start) begin
                    state_d   = StAccept;
                    overrun_d = 1'b0;
                end
            end
            StAccept: begin
                if (in_valid && in_ready_q) begin
                    rem_d    = in_data[RUN_W+2:3];
                    colour_d = in_data[2:0];
                    state_d  = StRun;
                end
            end
            StRun: begin
                // The frame end wins over the run; leftover pixels are dropped
                if (last_pixel) begin
                    state_d = StDone;
                    if (rem_q != '0) begin
                        overrun_d = 1'b1;
                    end
                end else if (rem_q == '0) begin
                    state_d = StAccept;
                end else begin
                    rem_d = rem_q - RUN_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_comb begin
        rc_clear   = (state_q == StIdle);
        rc_advance = (state_q == StRun) && !last_pixel;
        in_ready_d = (state_d == StAccept);
        wr_en_d    = (state_d == StRun);
        busy_d     = (state_d == StAccept) || (state_d == StRun);
        done_d     = (state_d == StDone);
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = rc_addr;
    assign wr_data  = colour_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_background_writer.sv
module tb_background_writer;
    import bg_pkg::*;

    localparam int TB_W   = 320;
    localparam int TB_H   = 12;
    localparam int TB_PIX = TB_W * TB_H;

    logic        Clk, Reset, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, wr_en, busy, done, overrun;
    logic [18:0] wr_addr;
    logic [2:0]  wr_data;

    background_writer #(
        .WIDTH  (TB_W),
        .HEIGHT (TB_H),
        .ADDR_W (19),
        .RUN_W  (5)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Reference model: the expected stream of pixel writes in frame order
    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  mp;  // pixels of the current frame already committed by the model

    function automatic void model_push(input int run, input int col);
        int len, n;
        wr_t w;
        len = run + 1;
        n   = (len < TB_PIX - mp) ? len : TB_PIX - mp;
        for (int i = 0; i < n; i++) begin
            w.addr = mp + i;
            w.data = col;
            exp_q.push_back(w);
        end
        mp += n;
    endfunction

    // Scoreboard: every write must match the next expected pixel
    always @(negedge Clk) begin
        wr_t e;
        if (!Reset && wr_en) begin
            if (exp_q.size() == 0) begin
                chk("spurious_write", wr_addr, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
                chk("raster_xy", {dut.u_raster.x_q, dut.u_raster.y_q},
                    {9'(e.addr % TB_W), 8'(e.addr / TB_W)});
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    // Offer one token, then follow it until in_ready returns or done pulses
    task automatic send_token(input int run, input int col, input int start_at,
                              output int nwr, output int first, output int cyc,
                              output bit saw_done);
        bg_token_t tok;
        int        k;
        tok.run    = run[4:0];
        tok.colour = col[2:0];
        in_data    = tok;
        in_valid   = 1'b1;
        nwr = 0; first = -1; cyc = 0; saw_done = 1'b0;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge Clk);
            k++;
        end
        if (!in_ready) begin
            chk("handshake_ready", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        model_push(run, col);
        do begin
            @(negedge Clk);
            in_valid = 1'b0;
            cyc++;
            if (wr_en) begin
                if (nwr == 0) first = wr_addr;
                nwr++;
            end
            if (done) saw_done = 1'b1;
            start = (cyc == start_at);
        end while (!in_ready && !done && cyc < 100);
        start = 1'b0;
    endtask

    // After done: one-cycle pulse, idle, stale token never taken
    task automatic post_frame(input bit exp_ov);
        int dn, rd, we;
        chk("done_pulse", done, 1);
        chk("done_overrun", overrun, exp_ov);
        in_data  = 8'hFF;
        in_valid = 1'b1;
        dn = 0; rd = 0; we = 0;
        repeat (6) begin
            @(negedge Clk);
            dn += int'(done);
            rd += int'(in_ready);
            we += int'(wr_en);
        end
        chk("done_extra", dn, 0);
        chk("idle_in_ready", rd, 0);
        chk("idle_wr_en", we, 0);
        chk("idle_busy", busy, 0);
        chk("overrun_sticky", overrun, exp_ov);
        in_valid = 1'b0;
    endtask

    typedef struct {
        int run;
        int col;
        int exp_first;
        int exp_n;
    } vec_t;

    vec_t vt[13];

    initial begin
        int  nwr, first, cyc, r, col, k;
        bit  sd, last;

        vt[0] = '{run: 0, col: 5, exp_first: 0, exp_n: 1};
        for (int i = 1; i <= 9; i++)
            vt[i] = '{run: 31, col: i % 8, exp_first: 1 + 32 * (i - 1), exp_n: 32};
        vt[10] = '{run: 10, col: 3, exp_first: 289, exp_n: 11};
        vt[11] = '{run: 31, col: 2, exp_first: 300, exp_n: 32};
        vt[12] = '{run: 7,  col: 6, exp_first: 332, exp_n: 8};

        Reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; mp = 0;
        repeat (2) @(negedge Clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("idle_no_ready", in_ready, 0);

        // Frame A: table vectors, stall, start during RUN, random fill
        pulse_start();
        chk("start_in_ready", in_ready, 1);
        chk("start_busy", busy, 1);
        for (int i = 0; i < 13; i++) begin
            send_token(vt[i].run, vt[i].col, 0, nwr, first, cyc, sd);
            chk($sformatf("vec%0d_first", i), first, vt[i].exp_first);
            chk($sformatf("vec%0d_nwr", i), nwr, vt[i].exp_n);
            chk($sformatf("vec%0d_ready_back", i), cyc, vt[i].exp_n + 1);
        end

        repeat (10) begin
            @(negedge Clk);
            chk("stall_wr_en", wr_en, 0);
            chk("stall_addr", wr_addr, mp);
            chk("stall_ready", in_ready, 1);
        end

        send_token(31, 4, 3, nwr, first, cyc, sd);
        chk("start_in_run_first", first, 340);
        chk("start_in_run_nwr", nwr, 32);
        chk("start_in_run_ready", in_ready, 1);
        chk("start_in_run_busy", busy, 1);

        while (mp < TB_PIX) begin
            k = $urandom_range(0, 2);
            repeat (k) @(negedge Clk);
            r = $urandom_range(0, 31);
            if (r + 1 > TB_PIX - mp) r = TB_PIX - mp - 1;
            col  = $urandom_range(0, 7);
            last = (mp + r + 1 == TB_PIX);
            send_token(r, col, 0, nwr, first, cyc, sd);
            chk("rand_nwr", nwr, r + 1);
            chk("rand_cycles", cyc, r + 2);
            chk("rand_done", sd, last);
        end
        post_frame(1'b0);

        // Frame B: final token of 32 pixels with only 4 left
        mp = 0;
        pulse_start();
        for (int i = 0; i < 119; i++) send_token(31, i % 8, 0, nwr, first, cyc, sd);
        send_token(27, 1, 0, nwr, first, cyc, sd);
        send_token(31, 6, 0, nwr, first, cyc, sd);
        chk("over_first", first, TB_PIX - 4);
        chk("over_nwr", nwr, 4);
        chk("over_saw_done", sd, 1);
        post_frame(1'b1);

        // Frame C: exact fill with full-length runs; start clears overrun
        mp = 0;
        pulse_start();
        chk("start_clears_overrun", overrun, 0);
        for (int i = 0; i < 120; i++) begin
            send_token(31, 7 - (i % 8), 0, nwr, first, cyc, sd);
            if (i < 119) chk("full_no_done", sd, 0);
        end
        chk("full_last_nwr", nwr, 32);
        chk("full_last_first", first, TB_PIX - 32);
        chk("full_saw_done", sd, 1);
        post_frame(1'b0);

        // Frame D: reset mid-run at address 1000, then reload from 0
        mp = 0;
        pulse_start();
        for (int i = 0; i < 31; i++) send_token(31, 3, 0, nwr, first, cyc, sd);
        in_data  = 8'hFD;  // run 31, colour 5
        in_valid = 1'b1;
        @(negedge Clk);
        model_push(31, 5);
        in_valid = 1'b0;
        k = 0;
        while (!(wr_en && wr_addr == 19'd1000) && k < 100) begin
            @(negedge Clk);
            k++;
        end
        chk("reach_1000", wr_addr, 1000);
        #1 Reset = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_wr_data", wr_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_overrun", overrun, 0);
        exp_q.delete();
        mp = 0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        pulse_start();
        send_token(0, 4, 0, nwr, first, cyc, sd);
        chk("after_rst_first", first, 0);
        chk("after_rst_nwr", nwr, 1);
        chk("after_rst_ready_back", cyc, 2);

        chk("all_writes_seen", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
